// File: rtl/pipe_multi_state.sv
`default_nettype none
// ============================================================================
// Module  : pipe_multi_state
// Brief   : Multi-channel pipe controller for the SpacyBird game core.
//           Staggered pipe spawning through a shared random-gap handshake,
//           per-channel IDLE/SPAWN/RUN/PASSED state machines, a saturating
//           score counter and a speed level that rises every SPEED_STEP
//           passed pipes.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_multi_state #(
  parameter int NUM_PIPES  = 3,
  parameter int SCORE_W    = 10,
  parameter int SPEED_W    = 3,
  parameter int SPEED_MAX  = 7,
  parameter int SPEED_STEP = 5,
  parameter int SPAWN_GAP  = 64
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iEnable,
  input  logic                 iTick,
  input  logic [NUM_PIPES-1:0] iPipe_Passed,
  input  logic [NUM_PIPES-1:0] iPipe_Gone,
  input  logic                 iRnd_Ready,
  output logic                 oRnd_Take,
  output logic [NUM_PIPES-1:0] oPipe_Pos_Rst,
  output logic [NUM_PIPES-1:0] oPipe_Pos_Move,
  output logic [NUM_PIPES-1:0] oActive,
  output logic                 oScore_Inc,
  output logic [SCORE_W-1:0]   oScore,
  output logic                 oPipe_Speed_Inc,
  output logic [SPEED_W-1:0]   oSpeed
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SPAWN  = 2'd1,
    ST_RUN    = 2'd2,
    ST_PASSED = 2'd3
  } pipe_state_e;

  localparam int TMR_W = $clog2(SPAWN_GAP + 1);
  localparam int CNT_W = $clog2(NUM_PIPES + 1);
  // Pass counter keeps the remainder below SPEED_STEP plus one cycle's worth
  // of simultaneous passes; one extra bit of headroom on top of that.
  localparam int PC_W  = $clog2(SPEED_STEP + NUM_PIPES + 1) + 1;
  localparam int SUM_W = ((SCORE_W > CNT_W) ? SCORE_W : CNT_W) + 1;

  localparam logic [TMR_W-1:0]   C_TMR_FULL  = TMR_W'(SPAWN_GAP);
  localparam logic [SUM_W-1:0]   C_SCORE_MAX = SUM_W'({SCORE_W{1'b1}});
  localparam logic [PC_W-1:0]    C_STEP      = PC_W'(SPEED_STEP);
  localparam logic [SPEED_W-1:0] C_SPEED_MAX = SPEED_W'(SPEED_MAX);

  pipe_state_e st_q [NUM_PIPES];
  pipe_state_e st_d [NUM_PIPES];

  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SPEED_W-1:0]   speed_q, speed_d;
  logic [PC_W-1:0]      pass_cnt_q, pass_cnt_d;
  logic                 rnd_take_q, rnd_take_d;
  logic [NUM_PIPES-1:0] pos_rst_q, pos_rst_d;
  logic [NUM_PIPES-1:0] pos_move_q, pos_move_d;
  logic                 score_inc_q, score_inc_d;
  logic                 speed_inc_q, speed_inc_d;

  logic [NUM_PIPES-1:0] spawn_sel;
  logic [NUM_PIPES-1:0] score_hit;
  logic                 any_spawning;
  logic                 any_idle;
  logic                 do_spawn;
  logic                 sel_found;
  logic [CNT_W-1:0]     n_scored;
  logic [SUM_W-1:0]     score_sum;
  logic [PC_W-1:0]      pass_sum;

  // Spawn arbitration: pick the lowest idle channel once the gap timer is full
  // and nobody is waiting on the random source; timer stalls during SPAWN.
  always_comb begin
    any_spawning = 1'b0;
    any_idle     = 1'b0;
    spawn_sel    = '0;
    sel_found    = 1'b0;
    timer_d      = timer_q;
    for (int k = 0; k < NUM_PIPES; k++) begin
      if (st_q[k] == ST_SPAWN) any_spawning = 1'b1;
      if (st_q[k] == ST_IDLE)  any_idle     = 1'b1;
    end
    do_spawn = iEnable && (timer_q == C_TMR_FULL) && !any_spawning && any_idle;
    for (int k = 0; k < NUM_PIPES; k++) begin
      if (do_spawn && !sel_found && (st_q[k] == ST_IDLE)) begin
        spawn_sel[k] = 1'b1;
        sel_found    = 1'b1;
      end
    end
    if (iEnable) begin
      if (do_spawn) begin
        timer_d = '0;
      end else if (!any_spawning && iTick && (timer_q < C_TMR_FULL)) begin
        timer_d = timer_q + TMR_W'(1);
      end
    end
  end

  // Per-channel next state plus the reset/move/score events each channel raises.
  always_comb begin
    st_d       = st_q;
    pos_rst_d  = '0;
    pos_move_d = '0;
    score_hit  = '0;
    rnd_take_d = 1'b0;
    for (int k = 0; k < NUM_PIPES; k++) begin
      if (iEnable) begin
        case (st_q[k])
          ST_IDLE: begin
            if (spawn_sel[k]) st_d[k] = ST_SPAWN;
          end
          ST_SPAWN: begin
            if (iRnd_Ready) begin
              st_d[k]      = ST_RUN;
              pos_rst_d[k] = 1'b1;
              rnd_take_d   = 1'b1;
            end
          end
          ST_RUN: begin
            pos_move_d[k] = iTick;
            if (iPipe_Gone[k]) begin
              st_d[k]      = ST_IDLE;
              score_hit[k] = iPipe_Passed[k];
            end else if (iPipe_Passed[k]) begin
              st_d[k]      = ST_PASSED;
              score_hit[k] = 1'b1;
            end
          end
          ST_PASSED: begin
            pos_move_d[k] = iTick;
            if (iPipe_Gone[k]) st_d[k] = ST_IDLE;
          end
          default: st_d[k] = ST_IDLE;
        endcase
      end
    end
  end

  // Score accumulation with saturation and speed level stepping.
  always_comb begin
    n_scored    = '0;
    score_d     = score_q;
    speed_d     = speed_q;
    pass_cnt_d  = pass_cnt_q;
    score_inc_d = 1'b0;
    speed_inc_d = 1'b0;
    for (int k = 0; k < NUM_PIPES; k++) begin
      n_scored = n_scored + CNT_W'(score_hit[k]);
    end
    score_sum = SUM_W'(score_q) + SUM_W'(n_scored);
    pass_sum  = pass_cnt_q + PC_W'(n_scored);
    if (iEnable) begin
      if (n_scored != '0) begin
        score_inc_d = 1'b1;
        score_d     = (score_sum > C_SCORE_MAX) ? C_SCORE_MAX[SCORE_W-1:0]
                                                : score_sum[SCORE_W-1:0];
      end
      pass_cnt_d = pass_sum;
      if (pass_sum >= C_STEP) begin
        pass_cnt_d = pass_sum - C_STEP;
        if (speed_q < C_SPEED_MAX) begin
          speed_d     = speed_q + SPEED_W'(1);
          speed_inc_d = 1'b1;
        end
      end
    end
  end

  // State and output registers; reset leaves the timer full so the first
  // enabled edge spawns immediately.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      for (int k = 0; k < NUM_PIPES; k++) st_q[k] <= ST_IDLE;
      timer_q     <= C_TMR_FULL;
      score_q     <= '0;
      speed_q     <= '0;
      pass_cnt_q  <= '0;
      rnd_take_q  <= 1'b0;
      pos_rst_q   <= '0;
      pos_move_q  <= '0;
      score_inc_q <= 1'b0;
      speed_inc_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_PIPES; k++) st_q[k] <= st_d[k];
      timer_q     <= timer_d;
      score_q     <= score_d;
      speed_q     <= speed_d;
      pass_cnt_q  <= pass_cnt_d;
      rnd_take_q  <= rnd_take_d;
      pos_rst_q   <= pos_rst_d;
      pos_move_q  <= pos_move_d;
      score_inc_q <= score_inc_d;
      speed_inc_q <= speed_inc_d;
    end
  end

  // Active flags decode directly from the registered channel states.
  always_comb begin
    oActive = '0;
    for (int k = 0; k < NUM_PIPES; k++) begin
      oActive[k] = (st_q[k] == ST_RUN) || (st_q[k] == ST_PASSED);
    end
  end

  assign oRnd_Take       = rnd_take_q;
  assign oPipe_Pos_Rst   = pos_rst_q;
  assign oPipe_Pos_Move  = pos_move_q;
  assign oScore_Inc      = score_inc_q;
  assign oScore          = score_q;
  assign oPipe_Speed_Inc = speed_inc_q;
  assign oSpeed          = speed_q;

endmodule
`default_nettype wire
